// File: rtl/next_pc_predictor_pkg.sv
// Shared types and constants for the fetch-stage next-PC predictor.
// Holds the 2-bit counter encoding and its saturating update rule.
package next_pc_predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_t;

   localparam logic [31:0] PC_INC    = 32'd4;
   localparam ctr_t        CTR_RESET = WNT;
   localparam ctr_t        CTR_ALLOC = WT;

   function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
      ctr_t res;
      res = ctr;
      if (taken) begin
         if (ctr != ST) res = ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != SNT) res = ctr_t'(ctr - 2'd1);
      end
      return res;
   endfunction

endpackage

// File: rtl/next_pc_predictor_sat_counter_table.sv
// Array of 2-bit saturating counters: one combinational read port,
// one write port that either allocates or applies a saturating step.
module sat_counter_table
   import next_pc_predictor_pkg::*;
#(
   parameter int ENTRIES = 32,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output ctr_t             rd_ctr,
   input  logic             wr_en,
   input  logic             wr_alloc,
   input  logic             wr_taken,
   input  logic [IDX_W-1:0] wr_idx
);

   ctr_t ctr_q [ENTRIES];

   assign rd_ctr = ctr_q[rd_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
      end else if (wr_en) begin
         ctr_q[wr_idx] <= wr_alloc ? CTR_ALLOC
                                   : sat_update(ctr_q[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/next_pc_predictor.sv
// Fetch next-PC generator with direct-mapped BTB and 2-bit counters.
// Define GSHARE_PREDICT_EN to index counters by idx XOR global history.
module next_pc_predictor
   import next_pc_predictor_pkg::*;
#(
   parameter int BTB_ENTRIES = 32,
   parameter int GHR_BITS    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] current_pc,
   input  logic        stall_in,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic [31:0] next_pc,
   output logic        pc_write,
   output logic        pred_taken,
   output logic        mispredict
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   if (BTB_ENTRIES < 2 || (1 << IDX_W) != BTB_ENTRIES) begin : g_chk_n
      $error("BTB_ENTRIES must be a power of two >= 2");
   end
   if (GHR_BITS < 1 || GHR_BITS > IDX_W) begin : g_chk_g
      $error("GHR_BITS must be in 1..log2(BTB_ENTRIES)");
   end

   logic             valid_q  [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
   logic [31:0]      target_q [BTB_ENTRIES];

   logic [IDX_W-1:0] idx, uidx, ctr_ridx, ctr_widx;
   logic [TAG_W-1:0] tag, utag;
   logic             lookup_hit, upd_hit, misp_raw;
   ctr_t             rd_ctr;
   logic             unused_lsb;

   assign idx        = current_pc[IDX_W+1:2];
   assign tag        = current_pc[31:IDX_W+2];
   assign uidx       = upd_pc[IDX_W+1:2];
   assign utag       = upd_pc[31:IDX_W+2];
   assign unused_lsb = ^{current_pc[1:0], upd_pc[1:0]};

`ifdef GSHARE_PREDICT_EN
   logic [GHR_BITS-1:0] ghr_q;

   assign ctr_ridx = idx ^ IDX_W'(ghr_q);
   assign ctr_widx = uidx ^ IDX_W'(ghr_q);

   always_ff @(posedge clk) begin
      if (reset) ghr_q <= '0;
      else if (upd_valid) ghr_q <= GHR_BITS'({ghr_q, upd_taken});
   end
`else
   assign ctr_ridx = idx;
   assign ctr_widx = uidx;
`endif

   sat_counter_table #(
      .ENTRIES (BTB_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (ctr_ridx),
      .rd_ctr   (rd_ctr),
      .wr_en    (upd_valid & (upd_hit | upd_taken)),
      .wr_alloc (~upd_hit),
      .wr_taken (upd_taken),
      .wr_idx   (ctr_widx)
   );

   assign lookup_hit = valid_q[idx] & (tag_q[idx] == tag) & (rd_ctr >= WT);
   assign upd_hit    = valid_q[uidx] & (tag_q[uidx] == utag);
   assign misp_raw   = upd_valid &
                       ((upd_taken != upd_pred_taken) |
                        (upd_taken & (upd_target != upd_pred_target)));

   always_comb begin
      next_pc    = current_pc + PC_INC;
      pc_write   = ~stall_in;
      pred_taken = 1'b0;
      mispredict = 1'b0;
      if (reset) begin
         next_pc  = '0;
         pc_write = 1'b1;
      end else begin
         pred_taken = lookup_hit;
         if (misp_raw) begin
            mispredict = 1'b1;
            pc_write   = 1'b1;
            next_pc    = upd_taken ? upd_target : upd_pc + PC_INC;
         end else if (lookup_hit) begin
            next_pc = target_q[idx];
         end
      end
   end

   // A taken outcome both allocates on a miss and refreshes target on a hit.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BTB_ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (upd_valid & upd_taken) begin
         valid_q[uidx]  <= 1'b1;
         tag_q[uidx]    <= utag;
         target_q[uidx] <= upd_target;
      end
   end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Self-checking bench for next_pc_predictor (default build, 32 entries).
// Directed scenarios followed by randomized traffic against a table model.
module tb_next_pc_predictor;

   localparam int N  = 32;
   localparam int IW = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] current_pc;
   logic        stall_in;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic [31:0] next_pc;
   logic        pc_write;
   logic        pred_taken;
   logic        mispredict;

   int checks = 0;
   int errors = 0;

   bit          m_valid  [N];
   logic [31:0] m_tag    [N];
   logic [31:0] m_target [N];
   int          m_ctr    [N];

   always #5 clk = ~clk;

   next_pc_predictor #(.BTB_ENTRIES(N), .GHR_BITS(5)) dut (
      .clk             (clk),
      .reset           (reset),
      .current_pc      (current_pc),
      .stall_in        (stall_in),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .next_pc         (next_pc),
      .pc_write        (pc_write),
      .pred_taken      (pred_taken),
      .mispredict      (mispredict)
   );

   function automatic int bidx(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic bit m_tag_hit(input logic [31:0] pc);
      return m_valid[bidx(pc)] && m_tag[bidx(pc)] == (pc >> (IW + 2));
   endfunction

   function automatic bit m_pred();
      return !reset && m_tag_hit(current_pc) && m_ctr[bidx(current_pc)] >= 2;
   endfunction

   function automatic bit m_misp();
      return !reset && upd_valid && (upd_taken != upd_pred_taken ||
             (upd_taken && upd_target != upd_pred_target));
   endfunction

   function automatic logic [31:0] m_next();
      if (reset) return 32'h0;
      if (m_misp()) return upd_taken ? upd_target : upd_pc + 32'd4;
      if (m_pred()) return m_target[bidx(current_pc)];
      return current_pc + 32'd4;
   endfunction

   function automatic bit m_pcw();
      return reset || m_misp() || !stall_in;
   endfunction

   // Advance one clock, folding the presented update into the model.
   task automatic cyc();
      int i;
      @(posedge clk);
      i = bidx(upd_pc);
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            m_valid[k] = 0;
            m_ctr[k]   = 1;
         end
      end else if (upd_valid) begin
         if (m_tag_hit(upd_pc)) begin
            m_ctr[i] = upd_taken ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1)
                                 : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
            if (upd_taken) m_target[i] = upd_target;
         end else if (upd_taken) begin
            m_valid[i]  = 1;
            m_tag[i]    = upd_pc >> (IW + 2);
            m_target[i] = upd_target;
            m_ctr[i]    = 2;
         end
      end
      @(negedge clk);
   endtask

   task automatic set_upd(input logic v, input logic [31:0] pc,
                          input logic t, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
      upd_valid       = v;
      upd_pc          = pc;
      upd_taken       = t;
      upd_target      = tgt;
      upd_pred_taken  = pt;
      upd_pred_target = ptgt;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      stall_in   = 1'b1;
      current_pc = 32'h0000_0abc;
      set_upd(1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0);
      #1;
      checks++;
      if (next_pc !== 32'h0 || pc_write !== 1'b1 ||
          pred_taken !== 1'b0 || mispredict !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got npc=%h pcw=%b pt=%b mp=%b want 0 1 0 0",
                  next_pc, pc_write, pred_taken, mispredict);
      end
      cyc();
      cyc();
      reset      = 1'b0;
      stall_in   = 1'b0;
      current_pc = 32'h100;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (next_pc !== 32'h104 || pred_taken !== 1'b0 || pc_write !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: got npc=%h pt=%b pcw=%b want 104 0 1",
                  next_pc, pred_taken, pc_write);
      end
   endtask

   task automatic test_allocate();
      current_pc = 32'h100;
      set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
      #1;
      checks++;
      if (mispredict !== 1'b1 || next_pc !== 32'h200 || pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL alloc_redirect: got mp=%b npc=%h pt=%b want 1 200 0",
                  mispredict, next_pc, pred_taken);
      end
      cyc();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (pred_taken !== 1'b1 || next_pc !== 32'h200) begin
         errors++;
         $display("FAIL alloc_lookup: got pt=%b npc=%h want 1 200",
                  pred_taken, next_pc);
      end
   endtask

   task automatic test_hazard();
      current_pc = 32'h140;
      set_upd(1'b1, 32'h140, 1'b1, 32'h7770_0000, 1'b1, 32'h7770_0000);
      #1;
      checks++;
      if (pred_taken !== 1'b0 || mispredict !== 1'b0 || next_pc !== 32'h144) begin
         errors++;
         $display("FAIL hazard_same: got pt=%b mp=%b npc=%h want 0 0 144",
                  pred_taken, mispredict, next_pc);
      end
      cyc();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (pred_taken !== 1'b1 || next_pc !== 32'h7770_0000) begin
         errors++;
         $display("FAIL hazard_next: got pt=%b npc=%h want 1 77700000",
                  pred_taken, next_pc);
      end
   endtask

   task automatic test_saturation();
      current_pc = 32'h100;
      for (int k = 0; k < 2; k++) begin
         set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
         #1;
         checks++;
         if (mispredict !== 1'b1 || next_pc !== 32'h104) begin
            errors++;
            $display("FAIL sat_nt_redirect%0d: got mp=%b npc=%h want 1 104",
                     k, mispredict, next_pc);
         end
         cyc();
      end
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (pred_taken !== 1'b0 || next_pc !== 32'h104) begin
         errors++;
         $display("FAIL sat_after_2nt: got pt=%b npc=%h want 0 104",
                  pred_taken, next_pc);
      end
      for (int k = 0; k < 5; k++) begin
         set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
         cyc();
      end
      set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
      cyc();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (pred_taken !== 1'b0 || next_pc !== 32'h104) begin
         errors++;
         $display("FAIL sat_after_1t: got pt=%b npc=%h want 0 104",
                  pred_taken, next_pc);
      end
      set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
      cyc();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (pred_taken !== 1'b1 || next_pc !== 32'h200) begin
         errors++;
         $display("FAIL sat_after_2t: got pt=%b npc=%h want 1 200",
                  pred_taken, next_pc);
      end
   endtask

   task automatic test_stall();
      current_pc = 32'h100;
      stall_in   = 1'b1;
      #1;
      checks++;
      if (pc_write !== 1'b0) begin
         errors++;
         $display("FAIL stall_hold: got pcw=%b want 0", pc_write);
      end
      set_upd(1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h900);
      #1;
      checks++;
      if (pc_write !== 1'b1 || next_pc !== 32'h304 || mispredict !== 1'b1) begin
         errors++;
         $display("FAIL stall_redirect: got pcw=%b npc=%h mp=%b want 1 304 1",
                  pc_write, next_pc, mispredict);
      end
      cyc();
      set_upd(1'b1, 32'h400, 1'b1, 32'h800, 1'b0, 32'h0);
      cyc();
      stall_in   = 1'b0;
      current_pc = 32'h400;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      checks++;
      if (pred_taken !== 1'b1 || next_pc !== 32'h800) begin
         errors++;
         $display("FAIL stall_update: got pt=%b npc=%h want 1 800",
                  pred_taken, next_pc);
      end
      current_pc = 32'h300;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || next_pc !== 32'h304) begin
         errors++;
         $display("FAIL nt_no_alloc: got pt=%b npc=%h want 0 304",
                  pred_taken, next_pc);
      end
   endtask

   task automatic test_alias_wrap();
      current_pc = 32'h180;
      #1;
      checks++;
      if (pred_taken !== 1'b0 || next_pc !== 32'h184) begin
         errors++;
         $display("FAIL alias_miss: got pt=%b npc=%h want 0 184",
                  pred_taken, next_pc);
      end
      current_pc = 32'hFFFF_FFFC;
      #1;
      checks++;
      if (next_pc !== 32'h0) begin
         errors++;
         $display("FAIL wrap_seq: got npc=%h want 0", next_pc);
      end
      set_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
      #1;
      checks++;
      if (next_pc !== 32'h0 || mispredict !== 1'b1) begin
         errors++;
         $display("FAIL wrap_redirect: got npc=%h mp=%b want 0 1",
                  next_pc, mispredict);
      end
      cyc();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   function automatic logic [31:0] rpc();
      if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
      return (32'($urandom_range(0, 3)) << 7) |
             (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   task automatic test_random();
      logic [31:0] en;
      for (int n = 0; n < 400; n++) begin
         reset      = ($urandom_range(0, 63) == 0);
         stall_in   = ($urandom_range(0, 3) == 0);
         current_pc = rpc();
         upd_valid  = $urandom_range(0, 1) == 1;
         upd_pc     = rpc();
         upd_taken  = $urandom_range(0, 1) == 1;
         upd_target = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 1) begin
            upd_pred_taken  = m_tag_hit(upd_pc) && m_ctr[bidx(upd_pc)] >= 2;
            upd_pred_target = upd_pred_taken ? m_target[bidx(upd_pc)] : upd_target;
            if (upd_pred_taken && upd_taken) upd_target = upd_pred_target;
         end else begin
            upd_pred_taken  = $urandom_range(0, 1) == 1;
            upd_pred_target = $urandom_range(0, 1) == 1 ? upd_target : $urandom;
         end
         #1;
         en = m_next();
         checks++;
         if (next_pc !== en || pred_taken !== m_pred() ||
             pc_write !== m_pcw() || mispredict !== m_misp()) begin
            errors++;
            $display("FAIL random%0d: got npc=%h pt=%b pcw=%b mp=%b want %h %b %b %b",
                     n, next_pc, pred_taken, pc_write, mispredict,
                     en, m_pred(), m_pcw(), m_misp());
         end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_hazard();
      test_saturation();
      test_stall();
      test_alias_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
